// File: rtl/echo_multitap_if.sv
// Sample/strobe bundle between the voice mixer and the multi-tap echo stage.
// The master drives samples and preset pulses; the slave returns echoed results.
interface echo_multitap_if #(
    parameter int WIDTH = 16
);
    logic signed [WIDTH-1:0] sample_in;
    logic                    in_ready;
    logic                    next_D;
    logic                    next_H;
    logic signed [WIDTH-1:0] out;
    logic                    out_ready;
    logic                    busy;

    modport master (
        output sample_in, in_ready, next_D, next_H,
        input  out, out_ready, busy
    );

    modport slave (
        input  sample_in, in_ready, next_D, next_H,
        output out, out_ready, busy
    );
endinterface

// File: rtl/echo_multitap.sv
// Multi-tap echo: each sample gets NTAPS delayed, progressively attenuated copies
// from a circular history, then saturates. Define ECHO_FEEDBACK_EN to store outputs (IIR echo).
module echo_multitap #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 1024,
    parameter int NTAPS      = 3,
    parameter int DELAY_STEP = 64,
    parameter int NUM_D      = 4,
    parameter int MAX_SHIFT  = 4
) (
    input  logic           clk,
    input  logic           reset,
    echo_multitap_if.slave bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int FW   = $clog2(DEPTH + 1);
    localparam int ACCW = WIDTH + NTAPS + 1;
    localparam int TW   = $clog2((NTAPS + 1) * NUM_D * DELAY_STEP + 1);
    localparam int SW   = $clog2((NTAPS + 1) * MAX_SHIFT + 1);
    localparam int KW   = $clog2(NTAPS + 2);
    localparam int DIW  = (NUM_D > 1) ? $clog2(NUM_D) : 1;
    localparam int HIW  = (MAX_SHIFT > 1) ? $clog2(MAX_SHIFT) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] TAP  = 2'd1;
    localparam logic [1:0] SAT  = 2'd2;

    localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACCW-1:0] MINV = {{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic [1:0]              state;
    logic [AW-1:0]           wr_ptr;
    logic [FW-1:0]           fill;
    logic [DIW-1:0]          d_idx;
    logic [HIW-1:0]          h_idx;
    logic signed [WIDTH-1:0] x;
    logic signed [ACCW-1:0]  acc;
    logic [TW-1:0]           d_lat;
    logic [TW-1:0]           off;
    logic [SW-1:0]           s_lat;
    logic [SW-1:0]           sh;
    logic [KW-1:0]           k;

    logic [WIDTH-1:0]        mem [DEPTH];
    logic [WIDTH-1:0]        rd_data;
    logic [AW-1:0]           rd_addr;

    logic [TW-1:0]           d_cur;
    logic [SW-1:0]           s_cur;
    logic [31:0]             shamt;
    logic                    tap_live;
    logic signed [ACCW-1:0]  tap_val;
    logic signed [WIDTH-1:0] sat_val;
    logic signed [WIDTH-1:0] wr_val;

    always_comb begin
        d_cur = TW'((32'(d_idx) + 32'd1) * 32'(DELAY_STEP));
        s_cur = SW'(32'(h_idx) + 32'd1);

        // off/sh always hold k*D and k*S for the tap whose data is on rd_data
        if (state == IDLE) begin
            rd_addr = wr_ptr - AW'(d_cur);
        end else begin
            rd_addr = wr_ptr - AW'(off + d_lat);
        end

        tap_live = (32'(off) <= 32'(fill));
        shamt    = (32'(sh) > 32'(WIDTH - 1)) ? 32'(WIDTH - 1) : 32'(sh);
        tap_val  = tap_live ? ACCW'($signed(rd_data) >>> shamt) : '0;

        if (acc > MAXV) begin
            sat_val = MAXV[WIDTH-1:0];
        end else if (acc < MINV) begin
            sat_val = MINV[WIDTH-1:0];
        end else begin
            sat_val = acc[WIDTH-1:0];
        end

`ifdef ECHO_FEEDBACK_EN
        wr_val = sat_val;
`else
        wr_val = x;
`endif
    end

    // History RAM: synchronous read, no reset so contents survive reset
    always_ff @(posedge clk) begin
        if (state == SAT) begin
            mem[wr_ptr] <= wr_val;
        end
        rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            fill          <= '0;
            d_idx         <= '0;
            h_idx         <= '0;
            x             <= '0;
            acc           <= '0;
            d_lat         <= '0;
            off           <= '0;
            s_lat         <= '0;
            sh            <= '0;
            k             <= '0;
            bus.out       <= '0;
            bus.out_ready <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.out_ready <= 1'b0;

            if (bus.next_D) begin
                d_idx <= (d_idx == DIW'(NUM_D - 1)) ? '0 : d_idx + DIW'(1);
            end
            if (bus.next_H) begin
                h_idx <= (h_idx == HIW'(MAX_SHIFT - 1)) ? '0 : h_idx + HIW'(1);
            end

            case (state)
                IDLE: begin
                    if (bus.in_ready) begin
                        x        <= bus.sample_in;
                        acc      <= ACCW'(bus.sample_in);
                        d_lat    <= d_cur;
                        s_lat    <= s_cur;
                        off      <= d_cur;
                        sh       <= s_cur;
                        k        <= KW'(1);
                        bus.busy <= 1'b1;
                        state    <= TAP;
                    end
                end
                TAP: begin
                    acc <= acc + tap_val;
                    off <= off + d_lat;
                    sh  <= sh + s_lat;
                    if (k == KW'(NTAPS)) begin
                        state <= SAT;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                SAT: begin
                    bus.out       <= sat_val;
                    bus.out_ready <= 1'b1;
                    wr_ptr        <= wr_ptr + AW'(1);
                    if (fill != FW'(DEPTH)) begin
                        fill <= fill + FW'(1);
                    end
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/echo_multitap.md
Name: echo_multitap

Overview:
- Parametrised successor to the single-delay echo stage; sits between the sine_reader/voice mixer and the audio output.
- Keeps a circular sample history of DEPTH signed samples and adds NTAPS delayed, progressively attenuated copies to each incoming sample.
- Output is saturated.
- Delay spacing and decay are stepped at run time by the next_D and next_H pulses.

Parameters:
WIDTH, 16, sample width (signed two's complement)
DEPTH, 1024, history buffer entries (power of two)
NTAPS, 3, number of echo taps (1..8)
DELAY_STEP, 64, tap spacing granularity in samples
NUM_D, 4, number of delay presets; requires NUM_D*DELAY_STEP*NTAPS <= DEPTH-1
MAX_SHIFT, 4, number of decay presets

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
sample_in  in  WIDTH  signed input sample
in_ready  in  1  one-cycle strobe: sample_in valid
next_D  in  1  advance delay preset (each high cycle = one step)
next_H  in  1  advance decay preset (each high cycle = one step)
out  out  WIDTH  signed echoed sample, held until next result
out_ready  out  1  one-cycle strobe: out valid
busy  out  1  high while a sample is being processed

Behaviour:
- Reset (reset low, async): out=0, out_ready=0, busy=0, FSM=IDLE, wr_ptr=0, fill=0, d_idx=0, h_idx=0. Buffer RAM contents are not cleared.
- Presets:
  - delay D = (d_idx+1)*DELAY_STEP; d_idx wraps NUM_D-1 -> 0.
  - shift S = h_idx+1; h_idx wraps MAX_SHIFT-1 -> 0.
- FSM states: IDLE, TAP, SAT.
- IDLE:
  - On in_ready, latch x=sample_in, D and S.
  - acc = sign-extended x, width WIDTH+NTAPS+1.
  - Issue RAM read at wr_ptr - D (mod DEPTH), k=1, busy=1, go to TAP.
- TAP (NTAPS cycles, synchronous-read RAM):
  - Tap k data arrives; acc += data >>> min(k*S, WIDTH-1), arithmetic shift.
  - Tap contributes 0 when k*D > fill, i.e. history not yet written.
  - Issue next read at wr_ptr - (k+1)*D; after tap NTAPS go to SAT.
- SAT:
  - out = acc clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; out_ready=1 for this one cycle.
  - Write buffer[wr_ptr] = x; wr_ptr++ (wraps DEPTH-1 -> 0); fill = min(fill+1, DEPTH).
  - busy=0, return to IDLE.
- Latency: in_ready sampled at edge 0 gives out_ready high in the cycle after edge NTAPS+1. Throughput is one sample per NTAPS+2 cycles.
- in_ready while busy: sample dropped, no state change.
- next_D/next_H: take effect on index in the same cycle they are sampled. A sample in flight keeps its latched D/S. If next_D and in_ready occur together, the sample uses the old preset.
- Reset mid-operation: aborts immediately, no out_ready, no buffer write.

Optional Feature:
ECHO_FEEDBACK_EN:
- Defined: SAT writes the saturated output, not x, into the buffer, giving a recirculating (IIR) echo. Taps beyond k=1 remain active.
- Undefined: pure feed-forward multi-tap echo, with x stored as above.

Test Plan:
- Defaults, presets 0/0: single impulse 16384 then zeros. Expected outputs: 16384 at sample 0, 8192 at sample 64, 4096 at sample 128, 2048 at sample 192, 0 elsewhere; each out_ready exactly 5 cycles after in_ready.
- Constant input 30000 for 300 samples. Expected outputs: 30000 for samples 0-63, 32767 (saturated) from sample 64 on. Constant -30000 gives -32768 from sample 64 on.
- Pulse next_D twice (D=192), then impulse 1000. Expected: 500 at sample 192, 250 at 384, 125 at 576. Four next_D pulses return d_idx to 0.
- in_ready strobed on consecutive cycles. Expected: second sample dropped, busy=1 during cycles 1-4, exactly one out_ready.
- Reset asserted two cycles after in_ready. Expected: out=0, out_ready never pulses, wr_ptr=0. The next impulse produces no echo from pre-reset data (fill=0).
- With ECHO_FEEDBACK_EN, impulse 16384 at D=64, S=1. Expected: sample 64 output 8192, sample 128 output 4096+4096=8192. Recirculation is verified against a bench reference model.
